vector_cmd_sequencer: RTL and testbench
=======================================

# vector_cmd_sequencer

Command sequencer directly upstream of the position counter in the vector generator datapath. It accepts LOAD (absolute beam position) and DRAW (relative vector with scaled duration) commands over a valid/ready handshake. It produces the `dv`, `go`, `haltstrobe` and `timer0` controls that the position counter consumes: a LOAD yields a single load pulse, and a DRAW yields a `go` window of exact, scale-dependent length.

## Interface
- `TIMER_W`, default 11: draw timer width; must hold 1024.
- `MAX_SCALE`, default 10: largest scale with a distinct duration; larger scales clamp to a 1-cycle draw.

Ports:
- `clk`  in  1: single clock; all logic on posedge.
- `reset_n`  in  1: synchronous reset, active-low.
- `cmd_valid`  in  1: command present.
- `cmd_ready`  out  1: sequencer can accept a command (IDLE only).
- `cmd_op`  in  1: 0 = LOAD, 1 = DRAW.
- `cmd_data`  in  12: LOAD = absolute position; DRAW = delta/rate word, passed through unchanged.
- `cmd_scale`  in  4: DRAW duration code; ignored for LOAD.
- `pause`  in  1: freezes an in-progress DRAW.
- `dv`  out  12: latched `cmd_data`, held until the next accepted command.
- `go`  out  1: count-enable window for the position counter.
- `haltstrobe`  out  1: one-cycle end-of-command pulse.
- `timer0`  out  1: high for the whole DRAW/END period; suppresses position loads.
- `busy`  out  1: state is not IDLE.

## Operation
- All outputs are registered. Reset values: `cmd_ready`=1, `go`=0, `haltstrobe`=0, `timer0`=0, `busy`=0, `dv`=0, timer=0, state=IDLE.
- The command is accepted on the edge where `cmd_valid && cmd_ready`. At that edge: `dv` <= `cmd_data`, `cmd_ready` <= 0, `busy` <= 1.
- States are IDLE, LOAD, DRAW and END.
- IDLE: `cmd_ready`=1 and every strobe is low. An accepted LOAD goes to LOAD; an accepted DRAW goes to DRAW.
- LOAD lasts exactly 1 cycle: `haltstrobe`=1, `timer0`=0, `go`=0. Downstream therefore sees a load strobe and latches `dv`. Next state is IDLE.
- DRAW:
  - The timer is loaded at accept with N = 1024 >> `cmd_scale`, i.e. 1024, 512 … 1 for scale 0..10. Scale 11..15 gives N = 1.
  - `timer0`=1 throughout.
  - `go` = !`pause`, registered, so it follows `pause` with one cycle of lag.
  - The timer decrements only on cycles where `go` is high. When a decrement takes the timer from 1 to 0, the next state is END.
  - Total `go`-high cycles per DRAW equal N exactly, regardless of pause pattern.
- END lasts exactly 1 cycle: `go`=0, `haltstrobe`=1, `timer0`=1. Downstream therefore does not load, because `timer0` masks the strobe. Next state is IDLE.
- Pause semantics:
  - Deasserting `go` clears the downstream rate-multiplier accumulators, so a paused DRAW resumes with fresh accumulator phase. This is accepted behaviour.
  - `pause` has no effect in IDLE, LOAD or END.
- `cmd_data` and `cmd_scale` changes while not accepting have no effect. `dv` is stable from accept until the next accept.
- Reset mid-command: on the next edge, state returns to IDLE and all outputs take their reset values. A partially drawn vector is not resumed.

## Timing
- Accept at edge T. The first state cycle begins at T+1.
- LOAD occupies cycle T+1: `haltstrobe` high there only. `cmd_ready` returns high at T+2. The next command can be accepted at edge T+2, giving a 2-cycle LOAD throughput.
- DRAW with no pause:
  - `go` is high for cycles T+1 … T+N.
  - END is cycle T+N+1, with `haltstrobe` high.
  - `cmd_ready` is high from T+N+2.
  - Total occupancy is N+2 cycles.
- DRAW with P paused cycles: `go`-low gaps add P cycles, so END lands at T+N+P+1.
- `timer0` rises at T+1 and falls at the start of IDLE, after the END cycle.
- `busy` equals !`cmd_ready` on every cycle.
- `go` and `haltstrobe` are never high in the same cycle.
- `go` is never high outside DRAW.

## Test plan
- Reset: hold `reset_n`=0 for 3 cycles with `cmd_valid`=1 -> no accept; all outputs at reset values; `cmd_ready`=1 on the first cycle after release.
- LOAD: `cmd_data`=12'h3A5 -> `dv`=12'h3A5 from T+1; `haltstrobe`=1 and `timer0`=0 at T+1 only; `go` never high; `cmd_ready` at T+2.
- DRAW scale sweep: scale=0 -> exactly 1024 `go` cycles; scale=4 -> 64; scale=10 -> 1; scale=15 -> 1. Each is followed by one `haltstrobe` with `timer0`=1.
- DRAW with pause: scale=7 (N=8), `pause` high for 3 cycles after the 2nd `go` cycle -> exactly 8 `go` cycles total; `haltstrobe` at T+12; `timer0` high T+1..T+12.
- Back-to-back: `cmd_valid` held high with queued LOAD, DRAW(scale 9), LOAD -> accepts at T, T+2, T+6; no overlap of `go` and `haltstrobe`.
- Reset mid-DRAW: scale=0, assert `reset_n`=0 after 100 `go` cycles -> `go`, `timer0` and `busy` low on the next edge; `haltstrobe` never pulses; a fresh DRAW after release runs a full 1024 cycles.

Source files
------------

// File: rtl/vector_cmd_sequencer.sv
// vector_cmd_sequencer
//   Command sequencer that sits in front of the vector generator position
//   counter. It takes LOAD and DRAW commands over a valid/ready handshake.
//   It turns each one into the dv / go / haltstrobe / timer0 controls that
//   the counter consumes.
//
// Ports
//   clk          in   system clock, all logic on posedge
//   reset_n      in   synchronous reset, active-low
//   cmd_valid    in   command present
//   cmd_ready    out  sequencer idle and able to accept
//   cmd_op       in   0 = LOAD, 1 = DRAW
//   cmd_data     in   LOAD position / DRAW delta-rate word
//   cmd_scale    in   DRAW duration code, N = 2^MAX_SCALE >> scale
//   pause        in   freezes an in-progress DRAW
//   dv           out  latched cmd_data, held until the next accept
//   go           out  count-enable window
//   haltstrobe   out  one-cycle end-of-command pulse
//   timer0       out  high through DRAW and END, masks position loads
//   busy         out  state is not IDLE
//
// State table
//   state   | meaning
//   IDLE    | ready for a command, all strobes low
//   LOAD    | single cycle, haltstrobe high so downstream latches dv
//   DRAW    | go = !pause (registered), timer counts go-high cycles down
//   END     | single cycle, haltstrobe high with timer0 masking the load

module vector_cmd_sequencer #(
   parameter int TIMER_W   = 11,
   parameter int MAX_SCALE = 10
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_op,
   input  logic [11:0] cmd_data,
   input  logic [3:0]  cmd_scale,
   input  logic        pause,
   output logic [11:0] dv,
   output logic        go,
   output logic        haltstrobe,
   output logic        timer0,
   output logic        busy
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DRAW = 2'd2,
      ST_END  = 2'd3
   } state_t;

   localparam logic [TIMER_W-1:0] N_MAX = TIMER_W'(1) << MAX_SCALE;
   localparam logic [TIMER_W-1:0] N_ONE = TIMER_W'(1);

   state_t             state_q, state_d;
   logic [TIMER_W-1:0] timer_q, timer_d;
   logic [11:0]        dv_q, dv_d;
   logic               cmd_ready_q, cmd_ready_d;
   logic               go_q, go_d;
   logic               haltstrobe_q, haltstrobe_d;
   logic               timer0_q, timer0_d;
   logic               busy_q, busy_d;

   logic               accept;
   logic [TIMER_W-1:0] n_load;

   assign accept = cmd_valid && cmd_ready_q;

   // Scales past MAX_SCALE would shift the load to zero, so they clamp to a
   // single-cycle draw instead.
   assign n_load = (cmd_scale > 4'(MAX_SCALE)) ? N_ONE : (N_MAX >> cmd_scale);

   // State and output registers
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         timer_q      <= '0;
         dv_q         <= '0;
         cmd_ready_q  <= 1'b1;
         go_q         <= 1'b0;
         haltstrobe_q <= 1'b0;
         timer0_q     <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         timer_q      <= timer_d;
         dv_q         <= dv_d;
         cmd_ready_q  <= cmd_ready_d;
         go_q         <= go_d;
         haltstrobe_q <= haltstrobe_d;
         timer0_q     <= timer0_d;
         busy_q       <= busy_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      dv_d    = dv_q;
      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               dv_d = cmd_data;
               if (cmd_op) begin
                  state_d = ST_DRAW;
                  timer_d = n_load;
               end else begin
                  state_d = ST_LOAD;
               end
            end
         end
         ST_LOAD: state_d = ST_IDLE;
         ST_DRAW: begin
            // Decrement on the registered go that downstream actually sees.
            // The go-high count then equals N whatever the pause pattern.
            if (go_q) begin
               timer_d = timer_q - N_ONE;
               if (timer_q == N_ONE) begin
                  state_d = ST_END;
               end
            end
         end
         ST_END: begin
            state_d = ST_IDLE;
            timer_d = '0;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Output logic: decoded from the next state so every output is a register
   always_comb begin
      cmd_ready_d  = (state_d == ST_IDLE);
      busy_d       = (state_d != ST_IDLE);
      go_d         = (state_d == ST_DRAW) && !pause;
      haltstrobe_d = (state_d == ST_LOAD) || (state_d == ST_END);
      timer0_d     = (state_d == ST_DRAW) || (state_d == ST_END);
   end

   assign cmd_ready  = cmd_ready_q;
   assign dv         = dv_q;
   assign go         = go_q;
   assign haltstrobe = haltstrobe_q;
   assign timer0     = timer0_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_vector_cmd_sequencer.sv
// Directed bench for vector_cmd_sequencer: table of single commands plus
// hand-written reset, pause, back-to-back and reset-mid-draw sequences.

module tb_vector_cmd_sequencer;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_op;
   logic [11:0] cmd_data;
   logic [3:0]  cmd_scale;
   logic        pause;
   logic [11:0] dv;
   logic        go;
   logic        haltstrobe;
   logic        timer0;
   logic        busy;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   vector_cmd_sequencer #(.TIMER_W(11), .MAX_SCALE(10)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_op     (cmd_op),
      .cmd_data   (cmd_data),
      .cmd_scale  (cmd_scale),
      .pause      (pause),
      .dv         (dv),
      .go         (go),
      .haltstrobe (haltstrobe),
      .timer0     (timer0),
      .busy       (busy)
   );

   typedef struct {
      logic        op;
      logic [11:0] data;
      logic [3:0]  scale;
      logic        pz;         // pause held high for the whole command
      int          exp_go;     // go-high cycles
      int          exp_halt;   // cycle offset of haltstrobe after accept
      int          exp_ready;  // cycle offset where cmd_ready returns
      logic        exp_t0h;    // timer0 during haltstrobe
      int          exp_t0cnt;  // timer0-high cycles
   } vec_t;

   vec_t tbl[9];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Issue one command and observe it until cmd_ready returns (bounded).
   // Pause, if requested, goes high once go_cnt reaches p_after and stays
   // high for p_len sampled cycles.
   task automatic run_cmd(input logic op, input logic [11:0] data,
                          input logic [3:0] scale, input logic pz,
                          input int p_after, input int p_len,
                          output int go_cnt, output int halt_off,
                          output int halt_cnt, output int ready_off,
                          output int t0h, output int t0cnt, output int bad);
      int pz_left;
      bit p_done;
      go_cnt = 0; halt_off = -1; halt_cnt = 0; ready_off = -1;
      t0h = -1; t0cnt = 0; bad = 0; pz_left = 0; p_done = 0;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = op; cmd_data = data; cmd_scale = scale;
      pause = pz;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      cmd_data  = ~data;
      cmd_scale = ~scale;
      for (int k = 1; k <= 1100; k++) begin
         if (go) go_cnt++;
         if (haltstrobe) begin
            halt_cnt++;
            if (halt_cnt == 1) begin
               halt_off = k;
               t0h = int'(timer0);
            end
         end
         if (timer0) t0cnt++;
         if (go && haltstrobe) bad++;
         if (busy == cmd_ready) bad++;
         if (dv !== data) bad++;
         if (cmd_ready) begin
            ready_off = k;
            break;
         end
         if (p_len > 0) begin
            if (pz_left > 0) begin
               pz_left--;
               if (pz_left == 0) pause = 1'b0;
            end else if (!p_done && go_cnt == p_after) begin
               pause = 1'b1;
               pz_left = p_len;
               p_done = 1;
            end
         end
         @(posedge clk); #1;
      end
      pause = 1'b0;
   endtask

   initial begin
      int go_cnt, halt_off, halt_cnt, ready_off, t0h, t0cnt, bad;
      int acc[3];
      int n_acc, ovl, hb, cnt;
      logic        b_op[3];
      logic [11:0] b_data[3];
      logic [3:0]  b_scale[3];
      bit r;

      //            op    data     scale pz  go    halt  ready t0h  t0cnt
      tbl[0] = '{1'b0, 12'h3A5, 4'd0,  1'b0, 0,    1,    2,    1'b0, 0};
      tbl[1] = '{1'b1, 12'h0C1, 4'd0,  1'b0, 1024, 1025, 1026, 1'b1, 1025};
      tbl[2] = '{1'b1, 12'h0F0, 4'd4,  1'b0, 64,   65,   66,   1'b1, 65};
      tbl[3] = '{1'b1, 12'h5A5, 4'd10, 1'b0, 1,    2,    3,    1'b1, 2};
      tbl[4] = '{1'b1, 12'hA5A, 4'd15, 1'b0, 1,    2,    3,    1'b1, 2};
      tbl[5] = '{1'b1, 12'h111, 4'd11, 1'b0, 1,    2,    3,    1'b1, 2};
      tbl[6] = '{1'b0, 12'hFFF, 4'd9,  1'b1, 0,    1,    2,    1'b0, 0};
      tbl[7] = '{1'b1, 12'h800, 4'd1,  1'b0, 512,  513,  514,  1'b1, 513};
      tbl[8] = '{1'b1, 12'h7E7, 4'd9,  1'b0, 2,    3,    4,    1'b1, 3};

      // Reset held with a command offered: nothing is accepted
      reset_n = 1'b0; cmd_valid = 1'b1; cmd_op = 1'b0;
      cmd_data = 12'h123; cmd_scale = 4'd0; pause = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check("reset_ctl", int'({cmd_ready, go, haltstrobe, timer0, busy}), 5'b10000);
      end
      check("reset_dv", int'(dv), 0);
      @(negedge clk);
      reset_n = 1'b1; cmd_valid = 1'b0;
      @(posedge clk); #1;
      check("release_ready", int'(cmd_ready), 1);
      check("release_dv", int'(dv), 0);

      for (int i = 0; i < 9; i++) begin
         run_cmd(tbl[i].op, tbl[i].data, tbl[i].scale, tbl[i].pz, 0, 0,
                 go_cnt, halt_off, halt_cnt, ready_off, t0h, t0cnt, bad);
         check($sformatf("v%0d_go_cnt", i), go_cnt, tbl[i].exp_go);
         check($sformatf("v%0d_halt_off", i), halt_off, tbl[i].exp_halt);
         check($sformatf("v%0d_halt_cnt", i), halt_cnt, 1);
         check($sformatf("v%0d_t0_at_halt", i), t0h, int'(tbl[i].exp_t0h));
         check($sformatf("v%0d_t0_cnt", i), t0cnt, tbl[i].exp_t0cnt);
         check($sformatf("v%0d_ready_off", i), ready_off, tbl[i].exp_ready);
         check($sformatf("v%0d_dv_busy_ovl", i), bad, 0);
      end

      // DRAW scale 7 with pause high for 3 cycles after the 2nd go cycle
      run_cmd(1'b1, 12'h6C3, 4'd7, 1'b0, 2, 3,
              go_cnt, halt_off, halt_cnt, ready_off, t0h, t0cnt, bad);
      check("pause_go_cnt", go_cnt, 8);
      check("pause_halt_off", halt_off, 12);
      check("pause_halt_cnt", halt_cnt, 1);
      check("pause_t0_at_halt", t0h, 1);
      check("pause_t0_cnt", t0cnt, 12);
      check("pause_ready_off", ready_off, 13);
      check("pause_dv_busy_ovl", bad, 0);

      // Back-to-back with cmd_valid held: LOAD, DRAW scale 9, LOAD
      b_op[0] = 1'b0; b_data[0] = 12'h1A1; b_scale[0] = 4'd0;
      b_op[1] = 1'b1; b_data[1] = 12'h2B2; b_scale[1] = 4'd9;
      b_op[2] = 1'b0; b_data[2] = 12'h3C3; b_scale[2] = 4'd0;
      n_acc = 0; ovl = 0;
      acc[0] = -1; acc[1] = -1; acc[2] = -1;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = b_op[0]; cmd_data = b_data[0]; cmd_scale = b_scale[0];
      for (int e = 0; e < 20; e++) begin
         r = cmd_ready;
         @(posedge clk);
         #1;
         if (r && cmd_valid) begin
            if (n_acc < 3) acc[n_acc] = e;
            n_acc++;
            if (n_acc < 3) begin
               cmd_op = b_op[n_acc]; cmd_data = b_data[n_acc]; cmd_scale = b_scale[n_acc];
            end else begin
               cmd_valid = 1'b0;
            end
         end
         if (go && haltstrobe) ovl++;
      end
      cmd_valid = 1'b0;
      check("b2b_n_acc", n_acc, 3);
      check("b2b_acc0", acc[0], 0);
      check("b2b_acc1", acc[1], 2);
      check("b2b_acc2", acc[2], 6);
      check("b2b_overlap", ovl, 0);
      check("b2b_dv", int'(dv), 12'h3C3);

      // Reset in the middle of a scale-0 DRAW, after 100 go cycles
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = 1'b1; cmd_data = 12'h2B4; cmd_scale = 4'd0;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      cnt = 0; hb = 0;
      for (int k = 0; k < 200; k++) begin
         if (go) cnt++;
         if (haltstrobe) hb++;
         if (cnt == 100) break;
         @(posedge clk); #1;
      end
      check("rstmid_go_before", cnt, 100);
      reset_n = 1'b0;
      @(posedge clk); #1;
      if (haltstrobe) hb++;
      check("rstmid_go", int'(go), 0);
      check("rstmid_timer0", int'(timer0), 0);
      check("rstmid_busy", int'(busy), 0);
      check("rstmid_ready", int'(cmd_ready), 1);
      check("rstmid_halt", hb, 0);
      @(negedge clk);
      reset_n = 1'b1;
      run_cmd(1'b1, 12'h0AB, 4'd0, 1'b0, 0, 0,
              go_cnt, halt_off, halt_cnt, ready_off, t0h, t0cnt, bad);
      check("rstmid_full_go", go_cnt, 1024);
      check("rstmid_full_halt", halt_off, 1025);
      check("rstmid_full_ready", ready_off, 1026);
      check("rstmid_full_ovl", bad, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
